vc_fifo: RTL and testbench

- Parametrised multi-virtual-channel input buffer for router ports; successor to the single-queue router FIFO.
- Holds VCN independent circular queues of DEPTH flits each, with shared write and read ports selected by VC index.
- Provides per-VC empty/full/packet-space status, first-word-fall-through read data, and sticky protocol-error flags.
- Sits between link receiver (writer) and switch allocator/crossbar (reader).

---
 rtl/vc_fifo.sv | 132 +++++++++++++
 tb/tb_vc_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo.sv
// Multi-virtual-channel router input buffer: VCN independent circular queues
// sharing one write port and one FWFT read port, with sticky protocol-error flags.
module vc_fifo #(
    parameter  int DATAW  = 35,
    parameter  int DEPTH  = 8,
    parameter  int VCN    = 2,
    parameter  int PKTLEN = 4,
    localparam int VCW    = (VCN > 1) ? $clog2(VCN) : 1,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [VCW-1:0]    wr_vc,
    input  logic [DATAW-1:0]  idata,
    input  logic              rd_en,
    input  logic [VCW-1:0]    rd_vc,
    output logic [DATAW-1:0]  odata,
    output logic [VCN-1:0]    empty,
    output logic [VCN-1:0]    full,
    output logic [VCN-1:0]    ordy,
    output logic [VCN*CW-1:0] cnt_out,
    output logic              err_ovf,
    output logic              err_udf
);

    logic [VCN-1:0]    rd_sel;
    logic [VCN-1:0]    wr_sel;
    logic [VCN-1:0]    pop_v;
    logic [VCN-1:0]    push_v;
    logic [VCN*AW-1:0] wr_ptr_flat;
    logic [VCN*AW-1:0] rd_ptr_flat;
    logic [AW-1:0]     wr_ptr_cur;
    logic [AW-1:0]     rd_ptr_cur;
    logic              push;
    logic              pop;
    logic              rd_hit;
    logic              err_ovf_reg;
    logic              err_udf_reg;

    logic [DATAW-1:0]  ram [VCN][DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < VCN; gi++) begin : g_vc
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic [CW:0]   space;

            // An out-of-range VC index matches no channel, so it can never push or pop.
            assign rd_sel[gi] = (rd_vc == VCW'(gi));
            assign wr_sel[gi] = (wr_vc == VCW'(gi));
            assign pop_v[gi]  = rd_en & rd_sel[gi] & ~empty[gi];
            assign push_v[gi] = wr_en & wr_sel[gi] & (~full[gi] | pop_v[gi]);

            assign empty[gi] = (cnt_reg == '0);
            assign full[gi]  = (cnt_reg == CW'(DEPTH));
            // cnt never exceeds DEPTH, so this subtraction cannot wrap.
            assign space     = (CW+1)'(DEPTH) - {1'b0, cnt_reg};
            assign ordy[gi]  = (space >= (CW+1)'(PKTLEN));

            always_comb begin
                cnt_next = cnt_reg;
                case ({push_v[gi], pop_v[gi]})
                    2'b10:   cnt_next = cnt_reg + CW'(1);
                    2'b01:   cnt_next = cnt_reg - CW'(1);
                    default: cnt_next = cnt_reg;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push_v[gi])
                        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
                    if (pop_v[gi])
                        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
                    cnt_reg <= cnt_next;
                end
            end

            assign wr_ptr_flat[gi*AW +: AW] = wr_ptr_reg;
            assign rd_ptr_flat[gi*AW +: AW] = rd_ptr_reg;
            assign cnt_out[gi*CW +: CW]     = cnt_reg;
        end
    endgenerate

    assign push   = |push_v;
    assign pop    = |pop_v;
    assign rd_hit = |(rd_sel & ~empty);

    always_comb begin
        wr_ptr_cur = '0;
        rd_ptr_cur = '0;
        for (int v = 0; v < VCN; v++) begin
            if (wr_sel[v])
                wr_ptr_cur = wr_ptr_flat[v*AW +: AW];
            if (rd_sel[v])
                rd_ptr_cur = rd_ptr_flat[v*AW +: AW];
        end
    end

    // Storage is never cleared; a flit is only visible once cnt covers its slot.
    always_ff @(posedge clk) begin
        if (push && !rst)
            ram[wr_vc][wr_ptr_cur] <= idata;
    end

    assign odata = rd_hit ? ram[rd_vc][rd_ptr_cur] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_udf_reg <= 1'b0;
        end else begin
            if (wr_en && !push)
                err_ovf_reg <= 1'b1;
            if (rd_en && !pop)
                err_udf_reg <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_udf = err_udf_reg;

endmodule

// File: tb/tb_vc_fifo.sv
// Bench for vc_fifo: per-VC queue model compared every cycle, plus directed
// transactions with hand-computed literal expectations.
module tb_vc_fifo;

    localparam int DATAW = 35;
    localparam int DEPTH = 8;
    localparam int VCN   = 2;
    localparam int PKT   = 4;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [0:0]       wr_vc = '0;
    logic [DATAW-1:0] idata = '0;
    logic             rd_en = 1'b0;
    logic [0:0]       rd_vc = '0;
    logic [DATAW-1:0] odata;
    logic [VCN-1:0]   empty;
    logic [VCN-1:0]   full;
    logic [VCN-1:0]   ordy;
    logic [VCN*CW-1:0] cnt_out;
    logic             err_ovf;
    logic             err_udf;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    logic [DATAW-1:0] q0[$];
    logic [DATAW-1:0] q1[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;

    vc_fifo #(.DATAW(DATAW), .DEPTH(DEPTH), .VCN(VCN), .PKTLEN(PKT)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_vc(wr_vc), .idata(idata),
        .rd_en(rd_en), .rd_vc(rd_vc), .odata(odata),
        .empty(empty), .full(full), .ordy(ordy), .cnt_out(cnt_out),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    function automatic int qsz(input int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [DATAW-1:0] qhead(input int v);
        if (qsz(v) == 0) return '0;
        return (v == 0) ? q0[0] : q1[0];
    endfunction

    // Reference behaviour: each VC is a bounded queue of DEPTH flits.
    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        logic [DATAW-1:0] junk;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
        end else begin
            do_pop  = rd_en && (qsz(int'(rd_vc)) > 0);
            do_push = wr_en && ((qsz(int'(wr_vc)) < DEPTH) || (do_pop && rd_vc == wr_vc));
            if (do_pop) begin
                if (rd_vc == 1'b0) junk = q0.pop_front();
                else               junk = q1.pop_front();
            end
            if (do_push) begin
                if (wr_vc == 1'b0) q0.push_back(idata);
                else               q1.push_back(idata);
            end
            if (wr_en && !do_push) m_ovf <= 1'b1;
            if (rd_en && !do_pop)  m_udf <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int v = 0; v < VCN; v++) begin
                chk($sformatf("model cnt[%0d]", v), 64'(cnt_out[v*CW +: CW]), 64'(qsz(v)));
                chk($sformatf("model empty[%0d]", v), 64'(empty[v]), 64'(qsz(v) == 0));
                chk($sformatf("model full[%0d]", v), 64'(full[v]), 64'(qsz(v) == DEPTH));
                chk($sformatf("model ordy[%0d]", v), 64'(ordy[v]), 64'((DEPTH - qsz(v)) >= PKT));
            end
            chk("model odata", 64'(odata), 64'(qhead(int'(rd_vc))));
            chk("model err_ovf", 64'(err_ovf), 64'(m_ovf));
            chk("model err_udf", 64'(err_udf), 64'(m_udf));
        end
    end

    task automatic step(input logic we, input logic [0:0] wv, input logic [DATAW-1:0] wd,
                        input logic re, input logic [0:0] rv);
        wr_en = we; wr_vc = wv; idata = wd; rd_en = re; rd_vc = rv;
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b wr=%0b vc%0d d=0x%0h rd=%0b vc%0d", $time, rst, we, wv, wd, re, rv);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset empty", 64'(empty), 64'h3);
        chk("reset full", 64'(full), 64'h0);
        chk("reset ordy", 64'(ordy), 64'h3);
        chk("reset cnt", 64'(cnt_out), 64'h0);
        chk("reset odata", 64'(odata), 64'h0);
        chk("reset errs", 64'({err_ovf, err_udf}), 64'h0);

        // Fill VC0 with 0x01..0x08.
        for (int i = 1; i <= 8; i++) step(1, 0, DATAW'(i), 0, 0);
        chk("fill cnt0", 64'(cnt_out[3:0]), 64'd8);
        chk("fill full", 64'(full), 64'h1);
        chk("fill ordy0", 64'(ordy[0]), 64'h0);
        chk("fill odata", 64'(odata), 64'h01);
        chk("fill vc1 empty", 64'(empty[1]), 64'h1);

        // Write to full VC0 while popping it.
        step(1, 0, DATAW'('hAA), 1, 0);
        chk("wr+rd cnt0", 64'(cnt_out[3:0]), 64'd8);
        chk("wr+rd ovf", 64'(err_ovf), 64'h0);
        for (int i = 0; i < 8; i++) begin
            chk("drain odata", 64'(odata), (i < 7) ? 64'(i + 2) : 64'hAA);
            step(0, 0, '0, 1, 0);
        end
        chk("drain empty", 64'(empty), 64'h3);

        // Interleaved VCs, then cross-VC simultaneous write/read.
        step(1, 0, DATAW'('h100), 0, 0);
        step(1, 1, DATAW'('h200), 0, 0);
        step(1, 0, DATAW'('h101), 0, 1);
        step(1, 1, DATAW'('h201), 0, 1);
        chk("ilv odata b0", 64'(odata), 64'h200);
        step(1, 0, DATAW'('h102), 1, 1);
        chk("ilv odata b1", 64'(odata), 64'h201);
        step(0, 0, '0, 1, 1);
        rd_vc = 1'b0; #1;
        chk("ilv odata a0", 64'(odata), 64'h100);
        step(0, 0, '0, 1, 0);
        chk("ilv odata a1", 64'(odata), 64'h101);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("ilv cnt", 64'(cnt_out), 64'h0);

        // Overflow and underflow.
        for (int i = 0; i < 8; i++) step(1, 0, DATAW'('h10 + i), 0, 0);
        step(1, 0, DATAW'('h77), 0, 0);
        chk("ovf cnt0", 64'(cnt_out[3:0]), 64'd8);
        chk("ovf flag", 64'(err_ovf), 64'h1);
        step(0, 0, '0, 0, 0);
        chk("ovf held", 64'(err_ovf), 64'h1);
        step(0, 0, '0, 1, 1);
        chk("udf odata", 64'(odata), 64'h0);
        chk("udf flag", 64'(err_udf), 64'h1);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);

        // Occupancy sweep on VC0.
        for (int c = 0; c <= 8; c++) begin
            chk($sformatf("sweep ordy c=%0d", c), 64'(ordy[0]), 64'(c <= 4));
            if (c < 8) step(1, 0, DATAW'('h40 + c), 0, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);

        // Wrap: 20 pushes and 20 pops with overlap.
        for (int i = 0; i < 4; i++) step(1, 0, DATAW'('h300 + i), 0, 0);
        for (int i = 4; i < 20; i++) begin
            chk("wrap odata", 64'(odata), 64'('h300 + i - 4));
            step(1, 0, DATAW'('h300 + i), 1, 0);
        end
        for (int i = 16; i < 20; i++) begin
            chk("wrap tail", 64'(odata), 64'('h300 + i));
            step(0, 0, '0, 1, 0);
        end

        // Mid-traffic reset with a concurrent write.
        for (int i = 0; i < 3; i++) step(1, 0, DATAW'('h500 + i), 0, 0);
        for (int i = 0; i < 2; i++) step(1, 1, DATAW'('h600 + i), 0, 0);
        rst = 1'b1;
        step(1, 0, DATAW'('h55), 0, 0);
        rst = 1'b0;
        chk("rst cnt", 64'(cnt_out), 64'h0);
        chk("rst empty", 64'(empty), 64'h3);
        chk("rst odata", 64'(odata), 64'h0);
        chk("rst errs", 64'({err_ovf, err_udf}), 64'h0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
